// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour types
// for the 640x480@60 raster pipeline.
package vga_pkg;

  localparam int CNT_W = 10;
  localparam int FCNT_W = 8;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BACK_DEF = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BACK_DEF = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF +
    H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF +
    V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [1:0] color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus
// display-window and sync-window decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int DISPLAY = 640,
  parameter int FRONT = 16,
  parameter int SYNC = 96,
  parameter int BACK = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_display,
  output logic             in_sync
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;
  localparam int SYNC_LO = DISPLAY + FRONT;
  localparam int SYNC_HI = SYNC_LO + SYNC;

  if (TOTAL > (1 << CNT_W)) begin : g_chk
    $error("axis total exceeds 10-bit counter");
  end

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == CNT_W'(TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign wrap = enable & w_last;
  assign in_display = (r_count < CNT_W'(DISPLAY));
  assign in_sync = (r_count >= CNT_W'(SYNC_LO)) &&
                   (r_count < CNT_W'(SYNC_HI));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing and blanking; define VGA_OUT_REG_EN
// to register syncs, display_on and colour (+1 clk).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT = V_FRONT_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BACK = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        r_in,
  input  logic [1:0]        g_in,
  input  logic [1:0]        b_in,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              display_on,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [1:0]        r_out,
  output logic [1:0]        g_out,
  output logic [1:0]        b_out
);

  logic [CNT_W-1:0]  w_h;
  logic [CNT_W-1:0]  w_v;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_h_disp;
  logic              w_v_disp;
  logic              w_h_sync;
  logic              w_v_sync;
  logic              w_de;
  logic              w_hs;
  logic              w_vs;
  rgb_t              w_in;
  rgb_t              w_rgb;
  rgb_t              w_pin;
  logic [FCNT_W-1:0] r_frame_cnt;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (1'b1),
    .count     (w_h),
    .wrap      (w_h_wrap),
    .in_display(w_h_disp),
    .in_sync   (w_h_sync)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (w_h_wrap),
    .count     (w_v),
    .wrap      (w_v_wrap),
    .in_display(w_v_disp),
    .in_sync   (w_v_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign pix_x = w_h;
  assign pix_y = w_v;
  assign frame_cnt = r_frame_cnt;
  assign line_start = (w_h == '0);
  assign frame_start = line_start && (w_v == '0);

  // Idle level is the inverse of the asserted level.
  assign w_de = w_h_disp & w_v_disp;
  assign w_hs = ~(w_h_sync ^ SYNC_ACTIVE_HIGH);
  assign w_vs = ~(w_v_sync ^ SYNC_ACTIVE_HIGH);
  assign w_in = {r_in, g_in, b_in};
  assign w_rgb = w_de ? w_in : '0;

`ifdef VGA_OUT_REG_EN
  logic r_de;
  logic r_hs;
  logic r_vs;
  rgb_t r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de  <= 1'b0;
      r_hs  <= ~SYNC_ACTIVE_HIGH;
      r_vs  <= ~SYNC_ACTIVE_HIGH;
      r_rgb <= '0;
    end else begin
      r_de  <= w_de;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_rgb <= w_rgb;
    end
  end

  assign display_on = r_de;
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign w_pin = r_rgb;
`else
  assign display_on = w_de;
  assign hsync = w_hs;
  assign vsync = w_vs;
  assign w_pin = w_rgb;
`endif

  assign r_out = w_pin.r;
  assign g_out = w_pin.g;
  assign b_out = w_pin.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen,
// run with a reduced raster so many frames fit.
module tb_vga_timing_gen;

  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VD = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam bit SAH = 1'b0;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic [5:0] rgb;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] r_in;
  logic [1:0] g_in;
  logic [1:0] b_in;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;
  logic [1:0] r_out;
  logic [1:0] g_out;
  logic [1:0] b_out;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  vga_timing_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(SAH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .display_on (display_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .line_start (line_start),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n clocks since reset release.
  function automatic exp_t model(input longint n,
                                 input logic [5:0] c);
    exp_t e;
    int   h;
    int   v;
    h = int'(n % HT);
    v = int'((n / HT) % VT);
    e.x = 10'(h);
    e.y = 10'(v);
    e.fc = 8'((n / FT) % 256);
    e.de = (h < HD) && (v < VD);
    e.hs = (h >= HD + HF && h < HD + HF + HS) ? SAH : !SAH;
    e.vs = (v >= VD + VF && v < VD + VF + VS) ? SAH : !SAH;
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    e.rgb = e.de ? c : 6'd0;
    return e;
  endfunction

  longint     n_cyc = 0;
  logic       reg_de = 1'b0;
  logic       reg_hs = !SAH;
  logic       reg_vs = !SAH;
  logic [5:0] reg_rgb = '0;

  task automatic cyc(input bit rst);
    logic [5:0] col;
    exp_t       c;
    exp_t       e;
    @(negedge clk);
    rst_n = !rst;
    col = 6'($urandom_range(0, 63));
    {r_in, g_in, b_in} = col;
    if (rst) begin
      n_cyc = 0;
      reg_de = 1'b0;
      reg_hs = !SAH;
      reg_vs = !SAH;
      reg_rgb = '0;
    end
    c = model(n_cyc, col);
    e = c;
`ifdef VGA_OUT_REG_EN
    e.de = reg_de;
    e.hs = reg_hs;
    e.vs = reg_vs;
    e.rgb = reg_rgb;
`endif
    q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      n_cyc++;
      reg_de = c.de;
      reg_hs = c.hs;
      reg_vs = c.vs;
      reg_rgb = c.rgb;
    end
  endtask

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pix_x", int'(pix_x), int'(e.x));
        chk("pix_y", int'(pix_y), int'(e.y));
        chk("display_on", int'(display_on), int'(e.de));
        chk("syncs", int'({hsync, vsync}),
            int'({e.hs, e.vs}));
        chk("strobes", int'({line_start, frame_start}),
            int'({e.ls, e.fs}));
        chk("frame_cnt", int'(frame_cnt), int'(e.fc));
        chk("colour", int'({r_out, g_out, b_out}),
            int'(e.rgb));
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    r_in = '0;
    g_in = '0;
    b_in = '0;
    repeat (3) cyc(1'b1);
    repeat (257 * FT + 3 * HT + 5) cyc(1'b0);
    repeat (2) cyc(1'b1);
    repeat (2 * FT + $urandom_range(0, FT)) cyc(1'b0);
    repeat ($urandom_range(1, 4)) cyc(1'b1);
    repeat (FT + HT) cyc(1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    #5;
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
